rr_arbiter8: RTL and testbench

//  Round-robin arbiter sharing one resource among 8 requesters.

---
 rtl/rr_arbiter8.sv | 149 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8 -- round-robin arbiter sharing one resource among 8 requesters.
//
// A winner is chosen from the request vector by scanning upward from a
// rotating priority pointer. The winner keeps the grant until it asserts done,
// drops its request, or has held the grant for MAX_HOLD cycles. After every
// release the pointer moves to the slot after the previous owner, and there is
// one idle cycle before the next grant.
//
// Handshake: req[i] is a level. Once requester i sees grant_oh[i]=1 it owns the
// resource until it pulses done for one cycle, drops req[i], or the arbiter
// revokes the grant (timeout pulses for one cycle while grant_valid=0). done is
// ignored while no grant is held.
//
// Ports
//   clk          in   1  clock, all state updates on posedge
//   rst          in   1  synchronous active-high reset
//   req          in   8  request vector, bit i = requester i
//   done         in   1  owner release strobe
//   grant_valid  out  1  1 while a grant is held
//   grant_idx    out  3  index of the current owner, 0 when idle
//   grant_oh     out  8  one-hot grant bus, 0 when idle
//   timeout      out  1  1-cycle pulse after a grant is revoked by MAX_HOLD
//   dbg_state    out  1  FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------

// 3-to-8 one-hot decoder used to build the grant bus.
module decoder3to8 (
    input  logic [2:0] sel,
    output logic [7:0] y
);
    always_comb begin
        y      = 8'h00;
        y[sel] = 1'b1;
    end
endmodule

module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_oh,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       idx_r, idx_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             timeout_r, timeout_n;

    logic [2:0]       win_idx;
    logic             win_found;
    logic [2:0]       cand;
    logic             owner_req;
    logic             hold_at_max;
    logic [7:0]       dec_out;

    // Winner scan: walk offsets from 7 down to 0 so that the smallest offset
    // from ptr (highest priority) is the last one written and therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req   = req[idx_r];
    assign hold_at_max = (hold_cnt == CNT_W'(MAX_HOLD));

    // Next-state logic.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = idx_r;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = GRANT;
                    idx_n   = win_idx;
                    hold_n  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_at_max) begin
                    state_n   = IDLE;
                    idx_n     = 3'd0;
                    ptr_n     = idx_r + 3'd1;
                    // A voluntary release on the same edge as the limit wins.
                    timeout_n = hold_at_max && !done && owner_req;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            idx_r     <= 3'd0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx_r     <= idx_n;
            hold_cnt  <= hold_n;
            timeout_r <= timeout_n;
        end
    end

    decoder3to8 u_dec (
        .sel (idx_r),
        .y   (dec_out)
    );

    assign grant_valid = (state == GRANT);
    assign grant_idx   = idx_r;
    assign grant_oh    = dec_out & {8{grant_valid}};
    assign timeout     = timeout_r;
    assign dbg_state   = state;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout;
    logic       dbg_state;

    int errors = 0;
    int checks = 0;

    // Reference model state (abstract: integers, plain modulo arithmetic).
    int m_valid, m_idx, m_ptr, m_hold, m_to;

    logic [7:0] exp_q[$];

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh),
        .timeout     (timeout),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge to the model using the inputs present at that edge.
    task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
        int found;
        if (rs) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
        end else if (m_valid == 0) begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (found == 0 && r[(m_ptr + k) % 8]) begin
                    found   = 1;
                    m_idx   = (m_ptr + k) % 8;
                    m_valid = 1;
                    m_hold  = 1;
                end
            end
        end else begin
            m_to = 0;
            if (d || !r[m_idx] || m_hold == MAX_HOLD) begin
                if (!d && r[m_idx]) m_to = 1;
                m_ptr   = (m_idx + 1) % 8;
                m_valid = 0;
                m_idx   = 0;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Drive inputs, take one edge, update the model, compare #1 after the edge.
    task automatic cycle(input logic [7:0] r, input logic d, input logic rs);
        logic [7:0] exp_oh;
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
        exp_oh = (m_valid != 0) ? (8'h01 << m_idx) : 8'h00;
        check("grant_valid", {7'b0, grant_valid}, 8'(m_valid));
        check("grant_idx",   {5'b0, grant_idx},   8'(m_idx));
        check("grant_oh",    grant_oh,            exp_oh);
        check("timeout",     {7'b0, timeout},     8'(m_to));
    endtask

    initial begin
        int cnt;
        logic [7:0] r;
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;

        // Test 1: reset with all requests present, then first grant is 0.
        cycle(8'hFF, 1'b0, 1'b1);
        cycle(8'hFF, 1'b0, 1'b1);
        check("t1_reset_oh", grant_oh, 8'h00);
        cycle(8'hFF, 1'b0, 1'b0);
        check("t1_first_oh", grant_oh, 8'h01);

        // Test 2: done every cycle -> grants 1..7 then wrap to 0, one bubble each.
        for (int k = 1; k < 8; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h00);
        for (int k = 0; k < 16; k++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            if (grant_valid === 1'b1) begin
                if (exp_q.size() > 0) check("t2_seq", {5'b0, grant_idx}, exp_q.pop_front());
                else check("t2_extra_grant", 8'h01, 8'h00 + 8'(exp_q.size()));
            end
        end
        check("t2_seq_left", 8'(exp_q.size()), 8'h00);

        // Test 3: ptr=5 after granting 4, req=0000_1001 -> 0 then 3.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h10, 1'b0, 1'b0);
        cycle(8'h10, 1'b1, 1'b0);
        cycle(8'h09, 1'b0, 1'b0);
        check("t3_wrap_idx", {5'b0, grant_idx}, 8'h00);
        cycle(8'h09, 1'b1, 1'b0);
        cycle(8'h09, 1'b0, 1'b0);
        check("t3_next_idx", {5'b0, grant_idx}, 8'h03);

        // Test 4: single requester, no done -> held MAX_HOLD cycles, timeout, regrant.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h04, 1'b0, 1'b0);
        cnt = (grant_oh === 8'h04) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cycle(8'h04, 1'b0, 1'b0);
            if (grant_oh !== 8'h04) break;
            cnt++;
        end
        check("t4_hold_len", 8'(cnt), 8'(MAX_HOLD));
        check("t4_timeout", {7'b0, timeout}, 8'h01);
        check("t4_valid_at_to", {7'b0, grant_valid}, 8'h00);
        cycle(8'h04, 1'b0, 1'b0);
        check("t4_regrant", grant_oh, 8'h04);
        check("t4_to_cleared", {7'b0, timeout}, 8'h00);

        // Test 5: owner 6 withdraws -> release, no timeout, ptr=7.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h40, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(8'h40, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        check("t5_released", {7'b0, grant_valid}, 8'h00);
        check("t5_no_timeout", {7'b0, timeout}, 8'h00);
        cycle(8'hFF, 1'b0, 1'b0);
        check("t5_ptr7", {5'b0, grant_idx}, 8'h07);

        // Test 6: reset mid-grant at the hold limit with done -> clean zero state.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h08, 1'b0, 1'b0);
        for (int k = 0; k < MAX_HOLD - 1; k++) cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h08, 1'b1, 1'b1);
        check("t6_valid", {7'b0, grant_valid}, 8'h00);
        check("t6_timeout", {7'b0, timeout}, 8'h00);
        cycle(8'hFF, 1'b0, 1'b0);
        check("t6_ptr0", {5'b0, grant_idx}, 8'h00);

        // Random traffic: sparse/dense requests, random done, rare reset.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0: r = 8'h00;
                1: r = 8'h01 << $urandom_range(0, 7);
                default: r = 8'($urandom);
            endcase
            cycle(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        // Long holds with a stable request set to exercise timeouts randomly.
        for (int k = 0; k < 200; k++) begin
            cycle(8'hA5, ($urandom_range(0, 29) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
